uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel receive path feeding the CPU-facing UART read interface; consumes the raw FPGA_Sin pin and produces one byte at a time.
- Uses a ready/valid handshake toward the memory-mapped IO logic: it exposes a byte plus a valid flag, which the IO logic pops during a load from the UART data address.
- Format is 8N1, LSB first, with mid-bit sampling, a one-byte holding register, and sticky framing and overrun error flags.

Parameters:
- ClockFreq, 50_000_000: system clock frequency in Hz.
- BaudRate, 115_200: serial bit rate.
- Derived constant SymbolEdgeTime = ClockFreq/BaudRate (integer division), the cycles per bit.
- Derived constant SampleTime = SymbolEdgeTime/2, the mid-bit offset.
- Derived constant CounterWidth = clog2(SymbolEdgeTime).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- SIn  in  1  raw serial input; asynchronous to Clock; idle level 1.
- DataOut  out  8  received byte; held stable while DataOutValid=1.
- DataOutValid  out  1  holding register contains an unread byte.
- DataOutReady  in  1  consumer accepts the byte; a pop occurs when Valid & Ready at a clock edge.
- FramingError  out  1  sticky; set when a stop bit samples 0.
- Overrun  out  1  sticky; set when a byte completes while the holding register is full.
- ClearErrors  in  1  synchronous clear of FramingError and Overrun.

Behaviour:
- Reset (Reset=0, asynchronous): the following values apply.
  - state=IDLE, synchronizer flops=1, counters=0, shift register=0.
  - DataOut=8'h00, DataOutValid=0, FramingError=0, Overrun=0.
  - A reset mid-frame abandons the frame with no output side effects.
- Input synchronizer: two flops; rx_s is SIn delayed 2 cycles. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s==0, go to START with counter=0.
  - START: the counter increments each cycle. At counter==SampleTime-1, sample rx_s.
    - If rx_s==0: go to DATA with counter=0, bitcnt=0.
    - If rx_s==1: treat as a glitch and return to IDLE. Nothing is reported.
  - DATA: the counter runs 0..SymbolEdgeTime-1, then wraps to 0 and samples rx_s.
    - The shift register shifts right with the new bit entering bit 7, so the byte assembles LSB first.
    - bitcnt increments per sample; after the 8th sample go to STOP with counter=0.
  - STOP: at counter==SymbolEdgeTime-1, sample rx_s and go to IDLE in the same edge.
    - rx_s==1, holding register empty (or being popped this cycle): load DataOut with the shift register and set DataOutValid=1.
    - rx_s==1, holding register full and not popped: discard the new byte, keep the old one, set Overrun=1.
    - rx_s==0: discard the byte and set FramingError=1. DataOut and DataOutValid are unchanged.
- Latency: DataOutValid rises 2 + SampleTime + 9*SymbolEdgeTime cycles after the SIn falling edge, ±1 cycle.
- Handshake:
  - A pop clears DataOutValid on the next edge.
  - DataOutReady while Valid=0 has no effect.
  - DataOut is not required to change on a pop.
- Simultaneous events:
  - Pop and load on the same edge: the new byte is loaded, Valid stays 1, Overrun is not set.
  - ClearErrors and an error set on the same edge: the set wins and the flag is 1.
- Back-to-back frames: returning to IDLE at mid stop bit lets the next start edge be detected without loss.
- Counter wrap: the counter never exceeds SymbolEdgeTime-1; bitcnt is 3 bits plus terminal detection.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams IDLE/START/DATA/STOP (2-bit);
  - the clog2 function;
  - the bit-time derivation expressions, which the transmitter reuses.
- One sub-module is natural: sync_2ff (parameterised reset value, here 1), reused by other async inputs.

Test Plan (ClockFreq=1000, BaudRate=100, so SymbolEdgeTime=10 and SampleTime=5):
1. Send 0x55 with Ready=0 -> DataOut=0x55, Valid=1 held for 50+ cycles; pulse Ready 1 cycle -> Valid=0 next edge, no errors.
2. Drive SIn low for 3 cycles, then high -> FSM returns to IDLE, Valid stays 0, no errors; a following 0x3C is received correctly.
3. Send 0xA3 with stop bit=0 -> Valid=0, FramingError=1; assert ClearErrors -> FramingError=0.
4. Send 0x11 then 0x22 with Ready=0 -> DataOut=0x11, Valid=1, Overrun=1.
5. Send 0x11 then 0x22, with Ready asserted exactly on the edge 0x22 loads -> DataOut=0x22, Valid=1, Overrun=0.
6. Assert Reset=0 during DATA bit 4 of 0x99 -> all outputs 0 immediately (async); release, then send 0xF0 -> DataOut=0xF0, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation,
// common to the receive and transmit paths.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Cycles per serial bit.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Offset from the start edge to the middle of a bit.
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

  // Never narrower than one bit, even for degenerate rates.
  function automatic int counter_width(input int clock_freq, input int baud_rate);
    int w;
    w = clog2(symbol_edge_time(clock_freq, baud_rate));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receive path and the memory-mapped IO logic.
interface uart_receiver_if;

  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  modport master (
    output DataOut,
    output DataOutValid,
    input  DataOutReady
  );

  modport slave (
    input  DataOut,
    input  DataOutValid,
    output DataOutReady
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// the input's idle level so no spurious edge appears after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register with
// ready/valid pop, sticky framing and overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SIn,
  uart_receiver_if.master   rx,
  output logic              FramingError,
  output logic              Overrun,
  input  logic              ClearErrors
);

  localparam int SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
  localparam int SampleTime     = sample_time(ClockFreq, BaudRate);
  localparam int CounterWidth   = counter_width(ClockFreq, BaudRate);

  localparam logic [CounterWidth-1:0] CNT_MID  = CounterWidth'(SampleTime - 1);
  localparam logic [CounterWidth-1:0] CNT_LAST = CounterWidth'(SymbolEdgeTime - 1);

  logic                    rx_s;
  logic [1:0]              state_q, state_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [2:0]              bitcnt_q, bitcnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [7:0]              dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;

  logic cnt_hit_mid;
  logic cnt_hit_last;
  logic stop_sample;
  logic pop;
  logic good_frame;
  logic load;
  logic ovr_set;
  logic ferr_set;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_sin (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .d_i    (SIn),
    .q_o    (rx_s)
  );

  assign cnt_hit_mid  = (cnt_q == CNT_MID);
  assign cnt_hit_last = (cnt_q == CNT_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (cnt_hit_mid) state_d = rx_s ? IDLE : DATA;
      DATA:    if (cnt_hit_last && (bitcnt_q == 3'd7)) state_d = STOP;
      STOP:    if (cnt_hit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, bit index and shift register advance with the FSM; stop_sample
  // marks the single edge where the frame is resolved.
  always_comb begin
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
      end
      START: begin
        if (cnt_hit_mid) begin
          cnt_d    = '0;
          bitcnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_hit_last) begin
          cnt_d    = '0;
          shift_d  = {rx_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_hit_last) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d    = '0;
        bitcnt_d = '0;
      end
    endcase
  end

  // A pop on the load edge frees the holding register, so that case loads
  // rather than overruns.
  assign pop        = valid_q & rx.DataOutReady;
  assign good_frame = stop_sample & rx_s;
  assign load       = good_frame & (~valid_q | rx.DataOutReady);
  assign ovr_set    = good_frame & valid_q & ~rx.DataOutReady;
  assign ferr_set   = stop_sample & ~rx_s;

  always_comb begin
    dout_d  = load ? shift_q : dout_q;
    valid_d = load ? 1'b1 : (pop ? 1'b0 : valid_q);
    ferr_d  = ferr_set ? 1'b1 : (ClearErrors ? 1'b0 : ferr_q);
    ovr_d   = ovr_set  ? 1'b1 : (ClearErrors ? 1'b0 : ovr_q);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      dout_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx.DataOut      = dout_q;
  assign rx.DataOutValid = valid_q;
  assign FramingError    = ferr_q;
  assign Overrun         = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit (load lands 98 edges
// after the edge on which a frame's start bit is driven).
module tb_uart_receiver;

  logic clk;
  logic rst_n;
  logic sin;
  logic ferr;
  logic ovr;
  logic clr;
  int   tests_run;
  int   tests_failed;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .ClockFreq (1000),
    .BaudRate  (100)
  ) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .SIn          (sin),
    .rx           (rx_if.master),
    .FramingError (ferr),
    .Overrun      (ovr),
    .ClearErrors  (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 sin = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 sin = b[i];
      repeat (10) @(posedge clk);
    end
    #1 sin = stop_bit;
    repeat (10) @(posedge clk);
    #1 sin = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_byte();
    @(posedge clk);
    #1 rx_if.DataOutReady = 1'b1;
    @(posedge clk);
    #1 rx_if.DataOutReady = 1'b0;
  endtask

  task automatic clear_errors();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sin = 1'b1;
    clr = 1'b0;
    rx_if.DataOutReady = 1'b0;
    #12;
    tests_run++; if (rx_if.DataOut !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", rx_if.DataOutValid); end
    tests_run++; if (ferr !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    tests_run++; if (ovr !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_receive_and_pop();
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (97) @(posedge clk);
        #2;
        tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: valid got %b expected 0", rx_if.DataOutValid); end
        @(posedge clk);
        #2;
        tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL latency_rise: valid got %b expected 1", rx_if.DataOutValid); end
      end
    join
    idle(50);
    tests_run++; if (rx_if.DataOut !== 8'h55) begin tests_failed++; $display("FAIL rx55_data: got %h expected 55", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL rx55_held: valid got %b expected 1", rx_if.DataOutValid); end
    pop_byte();
    tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL pop_clears: valid got %b expected 0", rx_if.DataOutValid); end
    tests_run++; if ({ferr, ovr} !== 2'b00) begin tests_failed++; $display("FAIL rx55_errors: got %b expected 00", {ferr, ovr}); end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1 sin = 1'b0;
    repeat (3) @(posedge clk);
    #1 sin = 1'b1;
    idle(20);
    tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid: got %b expected 0", rx_if.DataOutValid); end
    tests_run++; if ({ferr, ovr} !== 2'b00) begin tests_failed++; $display("FAIL glitch_errors: got %b expected 00", {ferr, ovr}); end
    send_frame(8'h3C, 1'b1);
    idle(5);
    tests_run++; if (rx_if.DataOut !== 8'h3C) begin tests_failed++; $display("FAIL rx3c_data: got %h expected 3c", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL rx3c_valid: got %b expected 1", rx_if.DataOutValid); end
    pop_byte();
  endtask

  task automatic test_framing();
    send_frame(8'hA3, 1'b0);
    idle(20);
    tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL framing_valid: got %b expected 0", rx_if.DataOutValid); end
    tests_run++; if (ferr !== 1'b1) begin tests_failed++; $display("FAIL framing_set: got %b expected 1", ferr); end
    tests_run++; if (ovr !== 1'b0) begin tests_failed++; $display("FAIL framing_ovr: got %b expected 0", ovr); end
    clear_errors();
    tests_run++; if (ferr !== 1'b0) begin tests_failed++; $display("FAIL framing_clear: got %b expected 0", ferr); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    tests_run++; if (rx_if.DataOut !== 8'h11) begin tests_failed++; $display("FAIL overrun_data: got %h expected 11", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL overrun_valid: got %b expected 1", rx_if.DataOutValid); end
    tests_run++; if (ovr !== 1'b1) begin tests_failed++; $display("FAIL overrun_set: got %b expected 1", ovr); end
    tests_run++; if (ferr !== 1'b0) begin tests_failed++; $display("FAIL overrun_ferr: got %b expected 0", ferr); end
    clear_errors();
    pop_byte();
    tests_run++; if ({rx_if.DataOutValid, ovr} !== 2'b00) begin tests_failed++; $display("FAIL overrun_cleanup: got %b expected 00", {rx_if.DataOutValid, ovr}); end
  endtask

  task automatic test_pop_on_load();
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (97) @(posedge clk);
        #1 rx_if.DataOutReady = 1'b1;
        @(posedge clk);
        #1 rx_if.DataOutReady = 1'b0;
      end
    join
    idle(5);
    tests_run++; if (rx_if.DataOut !== 8'h22) begin tests_failed++; $display("FAIL popload_data: got %h expected 22", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL popload_valid: got %b expected 1", rx_if.DataOutValid); end
    tests_run++; if (ovr !== 1'b0) begin tests_failed++; $display("FAIL popload_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_async_reset();
    fork
      send_frame(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (55) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++; if (rx_if.DataOut !== 8'h00) begin tests_failed++; $display("FAIL async_data: got %h expected 00", rx_if.DataOut); end
        tests_run++; if (rx_if.DataOutValid !== 1'b0) begin tests_failed++; $display("FAIL async_valid: got %b expected 0", rx_if.DataOutValid); end
        tests_run++; if ({ferr, ovr} !== 2'b00) begin tests_failed++; $display("FAIL async_errors: got %b expected 00", {ferr, ovr}); end
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    send_frame(8'hF0, 1'b1);
    idle(5);
    tests_run++; if (rx_if.DataOut !== 8'hF0) begin tests_failed++; $display("FAIL rxf0_data: got %h expected f0", rx_if.DataOut); end
    tests_run++; if (rx_if.DataOutValid !== 1'b1) begin tests_failed++; $display("FAIL rxf0_valid: got %b expected 1", rx_if.DataOutValid); end
    tests_run++; if ({ferr, ovr} !== 2'b00) begin tests_failed++; $display("FAIL rxf0_errors: got %b expected 00", {ferr, ovr}); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_receive_and_pop();
    test_glitch();
    test_framing();
    test_overrun();
    test_pop_on_load();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
